// File: rtl/freq_pkg.sv
// freq_pkg: rate class codes and FSM state encodings shared by the frequency meter
package freq_pkg;
  typedef logic [1:0] rate_t;
  localparam rate_t RATE_NONE  = 2'b00;
  localparam rate_t RATE_2HZ   = 2'b01;
  localparam rate_t RATE_5HZ   = 2'b10;
  localparam rate_t RATE_OTHER = 2'b11;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MEAS = 1'b1;
endpackage

// File: rtl/freq_meter_sync_edge.sv
// sync_edge: 2-flop synchroniser plus history flop; ports clkfreq, rst_n, sig_in -> rise (one-cycle rising-edge pulse)
module sync_edge (
  input  logic clkfreq,
  input  logic rst_n,
  input  logic sig_in,
  output logic rise
);
  logic s1_q, s2_q, s3_q, s1_d, s2_d, s3_d;
  always_comb begin
    s1_d = sig_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end
  always_ff @(posedge clkfreq or negedge rst_n)
    if (!rst_n) {s1_q, s2_q, s3_q} <= 3'b000;
    else {s1_q, s2_q, s3_q} <= {s1_d, s2_d, s3_d};
  assign rise = s2_q & ~s3_q;
endmodule

// File: rtl/freq_meter.sv
// freq_meter: classifies sig_in period as 2 Hz/5 Hz/other; ports clkfreq, rst_n, sig_in -> rate, period, valid, meas_stb
module freq_meter
  import freq_pkg::*;
#(
  parameter  int CLK_HZ  = 50_000_000,
  parameter  int TOL_DIV = 8,
  localparam int CW      = $clog2(CLK_HZ + 1)
) (
  input  logic          clkfreq,
  input  logic          rst_n,
  input  logic          sig_in,
  output logic [1:0]    rate,
  output logic [CW-1:0] period,
  output logic          valid,
  output logic          meas_stb
);
  localparam int P2 = CLK_HZ / 2;
  localparam int P5 = CLK_HZ / 5;
  localparam int T2 = P2 / TOL_DIV;
  localparam int T5 = P5 / TOL_DIV;
  localparam logic [CW-1:0] LO2 = CW'(P2 - T2);
  localparam logic [CW-1:0] HI2 = CW'(P2 + T2);
  localparam logic [CW-1:0] LO5 = CW'(P5 - T5);
  localparam logic [CW-1:0] HI5 = CW'(P5 + T5);
  localparam logic [CW-1:0] TMO = CW'(CLK_HZ);
  localparam logic [CW-1:0] ONE = CW'(1);
  logic          rise, meas, tmo;
  rate_t         cls;
  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, period_q, period_d;
  rate_t         rate_q, rate_d;
  logic          valid_q, valid_d, stb_q, stb_d;
  sync_edge u_sync (.clkfreq(clkfreq), .rst_n(rst_n), .sig_in(sig_in), .rise(rise));
  always_comb begin
    cls = (cnt_q >= LO2 && cnt_q <= HI2) ? RATE_2HZ :
          (cnt_q >= LO5 && cnt_q <= HI5) ? RATE_5HZ : RATE_OTHER;
    // an edge arriving on the timeout cycle takes priority over the timeout
    meas = rise && state_q == ST_MEAS;
    tmo = !rise && state_q == ST_MEAS && cnt_q == TMO;
    cnt_d = rise ? ONE : (cnt_q == TMO) ? cnt_q : cnt_q + ONE;
    state_d = rise ? ST_MEAS : tmo ? ST_IDLE : state_q;
    period_d = meas ? cnt_q : tmo ? '0 : period_q;
    rate_d = meas ? cls : tmo ? RATE_NONE : rate_q;
    valid_d = meas | (valid_q & ~tmo);
    stb_d = meas;
  end
  always_ff @(posedge clkfreq or negedge rst_n)
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      rate_q   <= RATE_NONE;
      valid_q  <= 1'b0;
      stb_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      rate_q   <= rate_d;
      valid_q  <= valid_d;
      stb_q    <= stb_d;
    end
  assign rate = rate_q;
  assign period = period_q;
  assign valid = valid_q;
  assign meas_stb = stb_q;
endmodule
